pipeline_stall_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage MIPS32 pipeline. It merges stall requests from ID (load-use), EX (multi-cycle mul/div) and MEM (bus wait) into the per-stage stall vector. Every pipeline register consumes that vector through its stall_current_stage/stall_next_stage pair. It also sequences exception flushes and the PC redirect, and keeps stall statistics and a stall watchdog.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 36 +++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared stall-bus layout, stall patterns and controller state encodings
// for the MIPS32 pipeline stall/flush scheduler.
package pipeline_stall_ctrl_pkg;

  localparam int STALL_BUS_WIDTH = 6;
  typedef logic [STALL_BUS_WIDTH-1:0] STALL_BUS;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // A stage stall freezes that stage and every stage upstream of it.
  localparam STALL_BUS STALL_PAT_ID  = STALL_BUS'((1 << (STALL_ID + 1)) - 1);
  localparam STALL_BUS STALL_PAT_EX  = STALL_BUS'((1 << (STALL_EX + 1)) - 1);
  localparam STALL_BUS STALL_PAT_MEM = STALL_BUS'((1 << (STALL_MEM + 1)) - 1);

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_PEND_EXC = 2'd1,
    CTRL_FLUSH    = 2'd2
  } ctrl_state_e;

  function automatic STALL_BUS stall_pattern(input logic mem, input logic ex,
                                             input logic id);
    STALL_BUS pat;
    pat = '0;
    if (mem)     pat = STALL_PAT_MEM;
    else if (ex) pat = STALL_PAT_EX;
    else if (id) pat = STALL_PAT_ID;
    return pat;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module pipeline_stall_ctrl_sat_counter #(
  parameter int              WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush scheduler: merges ID/EX/MEM stall requests into the
// per-stage stall vector, sequences exception flushes, and tracks stall stats.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int WDOG_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  exc_req,
  input  logic [ADDR_WIDTH-1:0] exc_target,
  input  logic                  stat_clear,
  output logic [5:0]            stall,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic                  wdog_timeout
);

  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);
  localparam logic [WDOG_W-1:0] WDOG_PRE = WDOG_W'(WDOG_LIMIT - 1);

  ctrl_state_e             state_p1;
  ctrl_state_e             state_nxt;
  logic [ADDR_WIDTH-1:0]   pend_pc_p1;
  logic                    take_exc;
  logic                    take_pend;
  logic                    load_pend;
  logic                    stall_any;
  logic                    wdog_hit;
  logic [WDOG_W-1:0]       wdog_cnt;

  // Reset also blanks the stall vector so the pipeline sees no stall while held.
  always_comb begin
    stall = '0;
    if (rst && (state_p1 != CTRL_FLUSH)) begin
      stall = stall_pattern(stall_req_mem, stall_req_ex, stall_req_id);
    end
  end

  assign stall_any = (stall != '0);

  always_comb begin
    state_nxt = state_p1;
    take_exc  = 1'b0;
    take_pend = 1'b0;
    load_pend = 1'b0;
    case (state_p1)
      CTRL_RUN: begin
        if (exc_req) begin
          if (stall_req_mem) begin
            load_pend = 1'b1;
            state_nxt = CTRL_PEND_EXC;
          end else begin
            take_exc  = 1'b1;
            state_nxt = CTRL_FLUSH;
          end
        end
      end
      CTRL_PEND_EXC: begin
        // First exception wins; later exc_req is ignored until the flush issues.
        if (!stall_req_mem) begin
          take_pend = 1'b1;
          state_nxt = CTRL_FLUSH;
        end
      end
      CTRL_FLUSH: begin
        state_nxt = CTRL_RUN;
      end
      default: begin
        state_nxt = CTRL_RUN;
      end
    endcase
  end

  // ---- registered control / redirect stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1   <= CTRL_RUN;
      flush      <= 1'b0;
      flush_pc   <= '0;
      pend_pc_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      flush    <= (state_nxt == CTRL_FLUSH);
      if (load_pend) pend_pc_p1 <= exc_target;
      if (take_exc)       flush_pc <= exc_target;
      else if (take_pend) flush_pc <= pend_pc_p1;
    end
  end

  pipeline_stall_ctrl_sat_counter #(
    .WIDTH (CNT_WIDTH),
    .MAX   ({CNT_WIDTH{1'b1}})
  ) u_stall_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_any),
    .clr   (stat_clear),
    .count (stall_cycles)
  );

  pipeline_stall_ctrl_sat_counter #(
    .WIDTH (WDOG_W),
    .MAX   (WDOG_MAX)
  ) u_wdog_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_any),
    .clr   (stat_clear | ~stall_any),
    .count (wdog_cnt)
  );

  // The flag sets on the same edge the consecutive count reaches the limit.
  assign wdog_hit = stall_any && (wdog_cnt >= WDOG_PRE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_timeout <= 1'b0;
    end else if (stat_clear) begin
      wdog_timeout <= 1'b0;
    end else if (wdog_hit) begin
      wdog_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed, table-driven bench for pipeline_stall_ctrl (WDOG_LIMIT=8, 4-bit stall counter).
module tb_pipeline_stall_ctrl;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  typedef struct {
    logic        id, ex, mem, exc;
    logic [31:0] tgt;
    logic        clr;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic [3:0]  e_cyc;
    logic        e_wdog;
  } vec_t;

  logic        clk, rst;
  logic        stall_req_id, stall_req_ex, stall_req_mem, exc_req, stat_clear;
  logic [31:0] exc_target;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic [3:0]  stall_cycles;
  logic        wdog_timeout;

  int checks;
  int failures;

  pipeline_stall_ctrl #(
    .ADDR_WIDTH (32),
    .CNT_WIDTH  (4),
    .WDOG_LIMIT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_req_id  (stall_req_id),
    .stall_req_ex  (stall_req_ex),
    .stall_req_mem (stall_req_mem),
    .exc_req       (exc_req),
    .exc_target    (exc_target),
    .stat_clear    (stat_clear),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .stall_cycles  (stall_cycles),
    .wdog_timeout  (wdog_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive one cycle: check the combinational stall mid-cycle, then the
  // registered outputs just after the closing edge.
  task automatic apply(input vec_t v, input string nm);
    stall_req_id  = v.id;
    stall_req_ex  = v.ex;
    stall_req_mem = v.mem;
    exc_req       = v.exc;
    exc_target    = v.tgt;
    stat_clear    = v.clr;
    #2;
    chk({nm, "_stall"}, {26'b0, stall}, {26'b0, v.e_stall});
    @(posedge clk);
    #1;
    chk({nm, "_flush"}, {31'b0, flush}, {31'b0, v.e_flush});
    chk({nm, "_pc"}, flush_pc, v.e_pc);
    chk({nm, "_cyc"}, {28'b0, stall_cycles}, {28'b0, v.e_cyc});
    chk({nm, "_wdog"}, {31'b0, wdog_timeout}, {31'b0, v.e_wdog});
  endtask

  vec_t vt[31];
  vec_t v;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    stall_req_id = 1'b0; stall_req_ex = 1'b0; stall_req_mem = 1'b0;
    exc_req = 1'b0; exc_target = 32'h0; stat_clear = 1'b0;

    //          id ex mem exc  tgt           clr  stall   fl  pc            cyc   wdog
    vt[0]  = '{Y, N, N, N, 32'h0,        N, 6'h07, N, 32'h0,        4'd1,  N};
    vt[1]  = '{Y, N, N, N, 32'h0,        N, 6'h07, N, 32'h0,        4'd2,  N};
    vt[2]  = '{Y, Y, Y, N, 32'h0,        N, 6'h1F, N, 32'h0,        4'd3,  N};
    vt[3]  = '{Y, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h0,        4'd4,  N};
    vt[4]  = '{Y, N, N, N, 32'h0,        N, 6'h07, N, 32'h0,        4'd5,  N};
    vt[5]  = '{N, N, N, N, 32'h0,        N, 6'h00, N, 32'h0,        4'd5,  N};
    vt[6]  = '{N, N, Y, N, 32'h0,        N, 6'h1F, N, 32'h0,        4'd6,  N};
    vt[7]  = '{N, Y, Y, N, 32'h0,        N, 6'h1F, N, 32'h0,        4'd7,  N};
    vt[8]  = '{Y, N, Y, N, 32'h0,        N, 6'h1F, N, 32'h0,        4'd8,  N};
    vt[9]  = '{N, N, N, N, 32'h0,        N, 6'h00, N, 32'h0,        4'd8,  N};
    vt[10] = '{N, N, N, Y, 32'hBFC00380, N, 6'h00, Y, 32'hBFC00380, 4'd8,  N};
    vt[11] = '{Y, Y, Y, Y, 32'h12345678, N, 6'h00, N, 32'hBFC00380, 4'd8,  N};
    vt[12] = '{N, N, N, N, 32'h0,        N, 6'h00, N, 32'hBFC00380, 4'd8,  N};
    vt[13] = '{N, N, Y, Y, 32'h80000180, N, 6'h1F, N, 32'hBFC00380, 4'd9,  N};
    vt[14] = '{N, N, Y, Y, 32'h0,        N, 6'h1F, N, 32'hBFC00380, 4'd10, N};
    vt[15] = '{N, N, Y, N, 32'h0,        N, 6'h1F, N, 32'hBFC00380, 4'd11, N};
    vt[16] = '{N, N, N, N, 32'h0,        N, 6'h00, Y, 32'h80000180, 4'd11, N};
    vt[17] = '{N, N, N, N, 32'h0,        N, 6'h00, N, 32'h80000180, 4'd11, N};
    vt[18] = '{N, N, N, N, 32'h0,        N, 6'h00, N, 32'h80000180, 4'd11, N};
    vt[19] = '{N, Y, N, N, 32'h0,        Y, 6'h0F, N, 32'h80000180, 4'd0,  N};
    vt[20] = '{N, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h80000180, 4'd1,  N};
    vt[21] = '{N, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h80000180, 4'd2,  N};
    vt[22] = '{N, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h80000180, 4'd3,  N};
    vt[23] = '{N, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h80000180, 4'd4,  N};
    vt[24] = '{N, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h80000180, 4'd5,  N};
    vt[25] = '{N, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h80000180, 4'd6,  N};
    vt[26] = '{N, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h80000180, 4'd7,  N};
    vt[27] = '{N, Y, N, N, 32'h0,        N, 6'h0F, N, 32'h80000180, 4'd8,  Y};
    vt[28] = '{N, N, N, N, 32'h0,        N, 6'h00, N, 32'h80000180, 4'd8,  Y};
    vt[29] = '{N, N, N, N, 32'h0,        N, 6'h00, N, 32'h80000180, 4'd8,  Y};
    vt[30] = '{N, N, N, N, 32'h0,        Y, 6'h00, N, 32'h80000180, 4'd0,  N};

    // Reset state while rst is held low
    #3;
    chk("rst_stall", {26'b0, stall}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_pc", flush_pc, 32'h0);
    chk("rst_cyc", {28'b0, stall_cycles}, 32'h0);
    chk("rst_wdog", {31'b0, wdog_timeout}, 32'h0);
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 31; i++) begin
      apply(vt[i], $sformatf("v%0d", i));
    end

    // Total-stall counter saturates at 4'hF; watchdog trips on the 8th cycle.
    for (int i = 1; i <= 17; i++) begin
      v = '{N, Y, N, N, 32'h0, N, 6'h0F, N, 32'h80000180,
            (i > 15) ? 4'd15 : 4'(i), (i >= 8) ? Y : N};
      apply(v, $sformatf("sat%0d", i));
    end
    v = '{N, N, N, N, 32'h0, N, 6'h00, N, 32'h80000180, 4'd15, Y};
    apply(v, "sat_idle");
    v = '{N, N, N, N, 32'h0, Y, 6'h00, N, 32'h80000180, 4'd0, N};
    apply(v, "sat_clr");

    // Async reset while an exception is pending behind a MEM stall
    v = '{N, N, Y, Y, 32'hDEADBEEF, N, 6'h1F, N, 32'h80000180, 4'd1, N};
    apply(v, "pend");
    exc_req = 1'b0;
    #2;
    chk("pend_hold_stall", {26'b0, stall}, 32'h1F);
    rst = 1'b0;
    #1;
    chk("arst_stall", {26'b0, stall}, 32'h0);
    chk("arst_flush", {31'b0, flush}, 32'h0);
    chk("arst_pc", flush_pc, 32'h0);
    chk("arst_cyc", {28'b0, stall_cycles}, 32'h0);
    chk("arst_wdog", {31'b0, wdog_timeout}, 32'h0);
    stall_req_mem = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v = '{N, N, N, N, 32'h0, N, 6'h00, N, 32'h0, 4'd0, N};
      apply(v, $sformatf("post_rst%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
